wav_trig_capture: RTL
=====================

WAV_TRIG_CAPTURE -- requirements
Module: wav_trig_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width.
REQ-002 SHALL have parameter ADDR_W, default 10, buffer depth DEPTH = 2^ADDR_W.
REQ-003 SHALL have parameter TO_W, default 24, auto-trigger timeout counter width.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports run in 1 (capture enable), din_valid in 1 (sample strobe) and din in DATA_W (sample).
REQ-007 SHALL have ports trig_level in DATA_W (threshold), trig_edge in 1 (0 rising, 1 falling) and auto_en in 1 (timeout forces trigger).
REQ-008 SHALL have ports timeout in TO_W (accepted samples before a forced trigger), pre_len in ADDR_W (pre-trigger samples) and decim in 8 (keep 1 of decim+1 valid samples).
REQ-009 SHALL have ports single in 1 (one-shot mode), arm in 1 (re-arm pulse), stop in 1 (freeze frame) and frame_ack in 1 (consumer finished reading).
REQ-010 SHALL have ports rd_addr in ADDR_W (logical index, 0 = oldest sample) and rd_data out DATA_W.
REQ-011 SHALL have ports frame_done out 1, trig_forced out 1 and state out 3 (encoding IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4).

Function
REQ-012 SHALL accept a sample only when din_valid=1 and the decimation counter is 0; the counter SHALL count 0..decim on valid samples and wrap to 0; decim=0 SHALL accept every valid sample.
REQ-013 SHALL write each accepted sample to the circular RAM at wr_ptr in PRE, ARMED and POST, then increment wr_ptr modulo DEPTH; it SHALL perform no writes in IDLE or DONE.
REQ-014 IDLE SHALL go to PRE when run=1; on entry to PRE, pre_len (clamped to DEPTH-1) and decim SHALL be latched, and the sample counter and prev-sample-valid flag SHALL be cleared.
REQ-015 PRE SHALL go to ARMED after pre_len accepted samples; pre_len=0 SHALL enter ARMED on the cycle after entering PRE.
REQ-016 Rising trigger SHALL be defined as prev<trig_level and cur>=trig_level; falling trigger as prev>trig_level and cur<=trig_level; both are evaluated only on accepted samples in ARMED with a valid prev.
REQ-017 With auto_en=1, ARMED SHALL count accepted samples; on reaching timeout without a trigger, the current sample SHALL be the trigger and trig_forced SHALL be set to 1 until the next PRE entry.
REQ-018 On the trigger, the trigger sample SHALL be written, start_ptr SHALL become trigger address minus pre_len (mod DEPTH), and the state SHALL become POST.
REQ-019 POST SHALL go to DONE after DEPTH-pre_len-1 further accepted samples, so logical index pre_len holds the trigger sample.
REQ-020 frame_done SHALL be 1 exactly while in DONE.
REQ-021 DONE SHALL go to PRE when single=0, stop=0 and frame_ack=1, or when single=1, stop=0 and arm=1; otherwise DONE SHALL hold.
REQ-022 stop SHALL NOT abort a capture in progress; it only holds DONE.
REQ-023 run=0 SHALL force IDLE from any state on the next edge; the RAM contents SHALL be retained.
REQ-024 rd_data SHALL equal RAM[(start_ptr+rd_addr) mod DEPTH] one clk after rd_addr is presented, in every state; the read port is fully independent of the write port.
REQ-025 A same-cycle read and write to the same address SHALL return the old data.

Reset
REQ-026 On rst_n=0: state=IDLE, wr_ptr=0, start_ptr=0, all counters=0, frame_done=0, trig_forced=0 and rd_data=0; the RAM contents are not reset.
REQ-027 Reset mid-capture SHALL discard the frame; after release, a capture SHALL restart only via run.

Structure
REQ-028 A shared package wav_pkg SHALL hold the state encoding constants and the trig_edge encoding.
REQ-029 The block SHALL instantiate one sub-module, wav_dpram: a simple dual-port RAM with a registered read and read-old-data behaviour.

Verification
REQ-030 Ramp 0..255 with DATA_W=8, ADDR_W=4, pre_len=4, level=100, rising edge -> rd_addr 4 returns 100, rd_addr 0 returns 96, and rd_addr 15 returns 111.
REQ-031 Falling edge on a 200->50 step with level 128 -> trigger on the first 50, trig_forced=0, and frame_done is asserted after 15 further samples (pre_len=0).
REQ-032 Constant input 10 with auto_en=1 and timeout=20 -> forced trigger on the 20th ARMED sample and trig_forced=1.
REQ-033 decim=2 on a ramp -> the stored frame holds every third sample (0, 3, 6, ...).
REQ-034 single=1 with stop pulsed -> DONE is held despite frame_ack; arm with stop=0 -> PRE on the next edge.
REQ-035 rst_n pulsed during POST -> state=IDLE and frame_done=0 immediately; with run=1, PRE is entered on the first edge after reset release.

Source files
------------

// File: rtl/wav_trig_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wav_pkg
// Brief   : Shared state and trigger-edge encodings for the waveform capture.
// Revision: 1.0
// ============================================================================
package wav_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PRE   = 3'd1;
    localparam logic [2:0] c_ST_ARMED = 3'd2;
    localparam logic [2:0] c_ST_POST  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic c_EDGE_RISE = 1'b0;
    localparam logic c_EDGE_FALL = 1'b1;

    // States in which accepted samples are written into the ring buffer
    function automatic logic is_capture(input logic [2:0] st);
        return (st == c_ST_PRE) || (st == c_ST_ARMED) || (st == c_ST_POST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wav_trig_capture_if.sv
`default_nettype none
// ============================================================================
// Module  : wav_trig_capture_if
// Brief   : Sample stream and frame read-back bundle.
// Revision: 1.0
// ============================================================================
interface wav_trig_capture_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output din_valid, output din, output rd_addr, input  rd_data);
    modport slave  (input  din_valid, input  din, input  rd_addr, output rd_data);
endinterface
`default_nettype wire

// File: rtl/wav_trig_capture_dpram.sv
`default_nettype none
// ============================================================================
// Module  : wav_dpram
// Brief   : Simple dual-port RAM, registered read, read-old-data on collision.
// Revision: 1.0
// ============================================================================
module wav_dpram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rd_data;

    // Storage is never reset so a frame survives rst_n and run toggling
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/wav_trig_capture.sv
`default_nettype none
// ============================================================================
// Module  : wav_trig_capture
// Brief   : Triggered waveform capture into a circular buffer with pre-trigger.
// Revision: 1.0
// ============================================================================
module wav_trig_capture
    import wav_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int TO_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    wav_trig_capture_if.slave bus,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic              auto_en,
    input  logic [TO_W-1:0]   timeout,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic [7:0]        decim,
    input  logic              single,
    input  logic              arm,
    input  logic              stop,
    input  logic              frame_ack,
    output logic              frame_done,
    output logic              trig_forced,
    output logic [2:0]        state
);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_start_ptr;
    logic [ADDR_W-1:0] r_smp_cnt;
    logic [ADDR_W-1:0] r_pre_len;
    logic [7:0]        r_decim;
    logic [7:0]        r_dec_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_vld;
    logic              r_trig_forced;

    logic              w_capturing;
    logic              w_accept;
    logic              w_enter_pre;
    logic              w_edge_hit;
    logic              w_timeout_hit;
    logic              w_trig;
    logic              w_pre_done;
    logic              w_post_done;
    logic [ADDR_W-1:0] w_smp_next;
    logic [ADDR_W-1:0] w_post_len;
    logic [ADDR_W-1:0] w_rd_phys;
    logic [TO_W:0]     w_to_next;
    logic [DATA_W-1:0] w_rd_data;

    assign w_capturing = is_capture(r_state);
    assign w_accept    = w_capturing && bus.din_valid && (r_dec_cnt == 8'd0);
    assign w_smp_next  = r_smp_cnt + ADDR_W'(1);
    // DEPTH-1-pre_len; pre_len is already bounded to DEPTH-1 by its width
    assign w_post_len  = ~r_pre_len;
    assign w_to_next   = {1'b0, r_to_cnt} + (TO_W+1)'(1);
    assign w_rd_phys   = r_start_ptr + bus.rd_addr;

    always_comb begin
        w_edge_hit = 1'b0;
        if (r_prev_vld) begin
            if (trig_edge == c_EDGE_RISE) begin
                w_edge_hit = (r_prev < trig_level) && (bus.din >= trig_level);
            end else begin
                w_edge_hit = (r_prev > trig_level) && (bus.din <= trig_level);
            end
        end
    end

    assign w_timeout_hit = auto_en && (w_to_next >= {1'b0, timeout});
    assign w_trig        = (r_state == c_ST_ARMED) && w_accept && (w_edge_hit || w_timeout_hit);
    assign w_pre_done    = (r_pre_len == '0) || (w_accept && (w_smp_next == r_pre_len));
    assign w_post_done   = (w_post_len == '0) || (w_accept && (w_smp_next == w_post_len));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; run=0 overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (!run) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:  w_state_nxt = c_ST_PRE;
                c_ST_PRE:   if (w_pre_done)  w_state_nxt = c_ST_ARMED;
                c_ST_ARMED: if (w_trig)      w_state_nxt = c_ST_POST;
                c_ST_POST:  if (w_post_done) w_state_nxt = c_ST_DONE;
                c_ST_DONE: begin
                    if (!stop && ((!single && frame_ack) || (single && arm))) begin
                        w_state_nxt = c_ST_PRE;
                    end
                end
                default:    w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        frame_done  = (r_state == c_ST_DONE);
        trig_forced = r_trig_forced;
        state       = r_state;
    end

    assign w_enter_pre = (w_state_nxt == c_ST_PRE) && (r_state != c_ST_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr      <= '0;
            r_start_ptr   <= '0;
            r_smp_cnt     <= '0;
            r_pre_len     <= '0;
            r_decim       <= '0;
            r_dec_cnt     <= '0;
            r_to_cnt      <= '0;
            r_prev        <= '0;
            r_prev_vld    <= 1'b0;
            r_trig_forced <= 1'b0;
        end else if (w_enter_pre) begin
            r_pre_len     <= pre_len;
            r_decim       <= decim;
            r_smp_cnt     <= '0;
            r_dec_cnt     <= '0;
            r_to_cnt      <= '0;
            r_prev_vld    <= 1'b0;
            r_trig_forced <= 1'b0;
        end else begin
            if (w_capturing && bus.din_valid) begin
                r_dec_cnt <= (r_dec_cnt == r_decim) ? 8'd0 : r_dec_cnt + 8'd1;
            end
            if (w_accept) begin
                r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                r_prev     <= bus.din;
                r_prev_vld <= 1'b1;
            end
            case (r_state)
                c_ST_PRE: begin
                    if (w_pre_done) begin
                        r_smp_cnt <= '0;
                    end else if (w_accept) begin
                        r_smp_cnt <= w_smp_next;
                    end
                end
                c_ST_ARMED: begin
                    if (w_accept && auto_en) begin
                        r_to_cnt <= w_to_next[TO_W-1:0];
                    end
                    // A genuine edge on the timeout sample is not reported as forced
                    if (w_trig) begin
                        r_start_ptr <= r_wr_ptr - r_pre_len;
                        r_smp_cnt   <= '0;
                        if (!w_edge_hit) begin
                            r_trig_forced <= 1'b1;
                        end
                    end
                end
                c_ST_POST: begin
                    if (w_accept) begin
                        r_smp_cnt <= w_smp_next;
                    end
                end
                default: ;
            endcase
        end
    end

    wav_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_accept),
        .wr_addr (r_wr_ptr),
        .wr_data (bus.din),
        .rd_addr (w_rd_phys),
        .rd_data (w_rd_data)
    );

    assign bus.rd_data = w_rd_data;

endmodule
`default_nettype wire
